// File: rtl/address_unit.sv
// ---------------------------------------------------------------------------
// address_unit
//   Owns the program counter (PC) and the effective-address register (AR),
//   drives the CPU address bus and performs X/Y index addition with
//   zero-page wrap and a one-cycle page-crossing fix-up of the high byte.
//
// Ports
//   i_clk         sole clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_ctrl[3:0]   {pc_out, pc_inc, ldlo, ldhi} from the addressing sequencer
//   i_data[7:0]   data bus byte captured by ldlo / ldhi
//   i_idx_add     add i_idx_val to AR this cycle
//   i_idx_val     index register value (X or Y)
//   i_idx_zp      index add wraps within page 00
//   i_pc_ld       load PC from AR (jump)
//   o_addr[15:0]  address bus: PC when pc_out, else AR (combinational)
//   o_pc[15:0]    current PC
//   o_busy        page-crossing fix-up cycle in progress
//   o_page_cross  registered pulse, high exactly during the fix-up cycle
// ---------------------------------------------------------------------------
module address_unit #(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_ctrl,
    input  logic [7:0]  i_data,
    input  logic        i_idx_add,
    input  logic [7:0]  i_idx_val,
    input  logic        i_idx_zp,
    input  logic        i_pc_ld,
    output logic [15:0] o_addr,
    output logic [15:0] o_pc,
    output logic        o_busy,
    output logic        o_page_cross
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FIX  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_pc;
    logic [15:0] r_ar;
    logic        r_page_cross;

    logic [15:0] w_pc_next;
    logic [15:0] w_ar_next;
    logic [8:0]  w_sum;
    logic        w_carry;
    logic        w_pc_out;
    logic        w_pc_inc;
    logic        w_ldlo;
    logic        w_ldhi;

    assign w_pc_out = i_ctrl[3];
    assign w_pc_inc = i_ctrl[2];
    assign w_ldlo   = i_ctrl[1];
    assign w_ldhi   = i_ctrl[0];

    // 9-bit low-byte sum; bit 8 is the carry into the high byte.
    assign w_sum = {1'b0, r_ar[7:0]} + {1'b0, i_idx_val};

    // A fix-up is needed only for an absolute index add that actually wins
    // priority (no byte load this cycle) and carries out of the low byte.
    assign w_carry = (r_state == S_IDLE) && !w_ldlo && !w_ldhi &&
                     i_idx_add && !i_idx_zp && w_sum[8];

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_carry) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        o_busy       = (r_state == S_FIX);
        o_page_cross = r_page_cross;
        o_pc         = r_pc;
        o_addr       = w_pc_out ? r_pc : r_ar;
    end

    // ---------------- PC next value ----------------
    // A jump takes AR as it stands before this edge, so a same-edge ldhi
    // does not reach the PC.
    always_comb begin
        w_pc_next = r_pc;
        if (i_pc_ld) begin
            w_pc_next = r_ar;
        end else if (w_pc_inc) begin
            w_pc_next = r_pc + 16'd1;
        end
    end

    // ---------------- AR next value ----------------
    always_comb begin
        w_ar_next = r_ar;
        if (r_state == S_FIX) begin
            // Byte loads and index adds are dropped here, not queued.
            w_ar_next = {r_ar[15:8] + 8'd1, r_ar[7:0]};
        end else begin
            case ({w_ldlo, w_ldhi})
                2'b10:   w_ar_next = {8'h00, i_data};
                2'b01:   w_ar_next = {i_data, r_ar[7:0]};
                2'b11:   w_ar_next = {i_data, i_data};
                default: begin
                    if (i_idx_add) begin
                        w_ar_next = {r_ar[15:8], w_sum[7:0]};
                    end
                end
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc         <= RESET_PC;
            r_ar         <= 16'h0000;
            r_page_cross <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_ar         <= w_ar_next;
            r_page_cross <= w_carry;
        end
    end

endmodule

// File: tb/tb_address_unit.sv
module tb_address_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic [3:0]  i_ctrl;
    logic [7:0]  i_data;
    logic        i_idx_add;
    logic [7:0]  i_idx_val;
    logic        i_idx_zp;
    logic        i_pc_ld;
    logic [15:0] o_addr;
    logic [15:0] o_pc;
    logic        o_busy;
    logic        o_page_cross;

    int n_checks = 0;
    int n_fail   = 0;

    address_unit #(.RESET_PC(16'hFFFC)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_ctrl       (i_ctrl),
        .i_data       (i_data),
        .i_idx_add    (i_idx_add),
        .i_idx_val    (i_idx_val),
        .i_idx_zp     (i_idx_zp),
        .i_pc_ld      (i_pc_ld),
        .o_addr       (o_addr),
        .o_pc         (o_pc),
        .o_busy       (o_busy),
        .o_page_cross (o_page_cross)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [7:0]  data;
        logic        idx_add;
        logic [7:0]  idx_val;
        logic        idx_zp;
        logic        pc_ld;
        logic [15:0] exp_ar;
        logic [15:0] exp_pc;
        logic        exp_busy;
        logic        exp_pcx;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [7:0] d, input logic ia,
                         input logic [7:0] iv, input logic iz, input logic pl);
        i_ctrl    = c;
        i_data    = d;
        i_idx_add = ia;
        i_idx_val = iv;
        i_idx_zp  = iz;
        i_pc_ld   = pl;
    endtask

    // Read the registered state between edges: AR through o_addr with
    // pc_out=0, PC through o_addr with pc_out=1, plus o_pc and the flags.
    task automatic read_state(output logic [15:0] ar, output logic [15:0] pc,
                              output logic [15:0] pc_bus, output logic b, output logic px);
        drive(4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        ar = o_addr;
        pc = o_pc;
        b  = o_busy;
        px = o_page_cross;
        i_ctrl = 4'b1000;
        #1;
        pc_bus = o_addr;
        i_ctrl = 4'b0000;
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_ar, input logic [15:0] e_pc,
                             input logic e_b, input logic e_px);
        logic [15:0] ar, pc, pcb;
        logic b, px;
        read_state(ar, pc, pcb, b, px);
        chk({tag, ".ar"},   ar,  e_ar);
        chk({tag, ".pc"},   pc,  e_pc);
        chk({tag, ".bus_pc"}, pcb, e_pc);
        chk({tag, ".busy"}, {15'd0, b},  {15'd0, e_b});
        chk({tag, ".pcx"},  {15'd0, px}, {15'd0, e_px});
    endtask

    task automatic step_edge();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // reference model state
        int m_pc, m_ar, m_fix;
        int sum;
        logic [3:0] c;
        logic [7:0] d, iv;
        logic ia, iz, pl;

        drive(4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        #12;
        check_all("reset", 16'h0000, 16'hFFFC, 1'b0, 1'b0);
        i_rst_n = 1'b1;

        // ctrl, data, idx_add, idx_val, zp, pc_ld, exp_ar, exp_pc, busy, pcx
        vq.push_back('{4'b1100, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'hFFFD, 1'b0, 1'b0});
        vq.push_back('{4'b1100, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'hFFFE, 1'b0, 1'b0});
        vq.push_back('{4'b1100, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{4'b1100, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0});
        vq.push_back('{4'b1110, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0034, 16'h0001, 1'b0, 1'b0});
        vq.push_back('{4'b1101, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 16'h0002, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0});
        vq.push_back('{4'b0010, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h00F0, 16'h1234, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 8'h00, 1'b1, 8'h20, 1'b1, 1'b0, 16'h0010, 16'h1234, 1'b0, 1'b0});
        vq.push_back('{4'b0010, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h00F0, 16'h1234, 1'b0, 1'b0});
        vq.push_back('{4'b0001, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 16'h12F0, 16'h1234, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0, 16'h1210, 16'h1234, 1'b1, 1'b1});
        vq.push_back('{4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'h1310, 16'h1234, 1'b0, 1'b0});
        vq.push_back('{4'b0010, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h00F0, 16'h1234, 1'b0, 1'b0});
        vq.push_back('{4'b0001, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 16'hFFF0, 16'h1234, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0, 16'hFF10, 16'h1234, 1'b1, 1'b1});
        vq.push_back('{4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0010, 16'h1234, 1'b0, 1'b0});
        vq.push_back('{4'b0010, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h00F0, 16'h1234, 1'b0, 1'b0});
        vq.push_back('{4'b0001, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 16'h12F0, 16'h1234, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0, 16'h1210, 16'h1234, 1'b1, 1'b1});
        // ldlo during FIX is dropped, PC increment still honoured
        vq.push_back('{4'b0110, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 16'h1310, 16'h1235, 1'b0, 1'b0});
        vq.push_back('{4'b0011, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 16'h5A5A, 16'h1235, 1'b0, 1'b0});
        // jump in the same cycle as ldhi: PC gets the old AR
        vq.push_back('{4'b0001, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1, 16'h775A, 16'h5A5A, 1'b0, 1'b0});

        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k].ctrl, vq[k].data, vq[k].idx_add, vq[k].idx_val, vq[k].idx_zp, vq[k].pc_ld);
            step_edge();
            check_all($sformatf("vec%0d", k), vq[k].exp_ar, vq[k].exp_pc, vq[k].exp_busy, vq[k].exp_pcx);
        end

        // Reset pulse between edges while in FIX
        drive(4'b0010, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0); step_edge();
        drive(4'b0001, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0); step_edge();
        drive(4'b0000, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0); step_edge();
        check_all("prefix", 16'h1210, 16'h5A5A, 1'b1, 1'b1);
        #1;
        i_rst_n = 1'b0;
        check_all("rst_mid", 16'h0000, 16'hFFFC, 1'b0, 1'b0);
        #1;
        i_rst_n = 1'b1;
        drive(4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step_edge();
        check_all("post_rst", 16'h0000, 16'hFFFC, 1'b0, 1'b0);

        // Randomised run against a behavioural model
        m_pc = 16'hFFFC;
        m_ar = 0;
        m_fix = 0;
        for (int n = 0; n < 400; n++) begin
            c  = 4'($urandom);
            d  = 8'($urandom);
            ia = 1'($urandom);
            iv = 8'($urandom);
            iz = ($urandom_range(0, 3) == 0);
            pl = ($urandom_range(0, 7) == 0);
            if (c[1] || c[0]) begin
                if ($urandom_range(0, 1) == 0) c[1:0] = 2'b00;
            end
            drive(c, d, ia, iv, iz, pl);
            step_edge();

            // model update from pre-edge state
            if (pl)        m_pc = m_ar;
            else if (c[2]) m_pc = (m_pc + 1) % 65536;
            if (m_fix != 0) begin
                m_ar  = (m_ar + 256) % 65536;
                m_fix = 0;
            end else if (c[1] && c[0]) begin
                m_ar = int'(d) * 257;
            end else if (c[1]) begin
                m_ar = int'(d);
            end else if (c[0]) begin
                m_ar = int'(d) * 256 + (m_ar % 256);
            end else if (ia) begin
                sum  = (m_ar % 256) + int'(iv);
                m_ar = (m_ar / 256) * 256 + (sum % 256);
                if (!iz && sum > 255) m_fix = 1;
            end
            check_all($sformatf("rnd%0d", n), 16'(m_ar), 16'(m_pc), m_fix != 0, m_fix != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/address_unit.md
# address_unit

- Datapath stage directly downstream of the addressing-mode sequencer.
- Consumes the sequencer's 4-bit control word `{pc_out, pc_inc, ldlo, ldhi}` and owns the 16-bit program counter (PC) and the 16-bit effective-address register (AR).
- Drives the CPU address bus.
- Also performs X/Y index addition with zero-page wrap and the 6502-style one-cycle page-crossing fix-up.

## Interface

Parameters:
- `RESET_PC`, default 16'hFFFC: PC value on reset (reset-vector fetch address).

Ports:
- `i_clk`, input, 1: sole clock; all state changes on the rising edge.
- `i_rst_n`, input, 1: reset, asynchronous and active-low.
- `i_ctrl`, input, 4: `{pc_out, pc_inc, ldlo, ldhi}` from the sequencer.
- `i_data`, input, 8: data bus byte latched by `ldlo`/`ldhi`.
- `i_idx_add`, input, 1: add `i_idx_val` to AR this cycle.
- `i_idx_val`, input, 8: index register value (X or Y, selected upstream).
- `i_idx_zp`, input, 1: index add is zero-page (wrap within page 00).
- `i_pc_ld`, input, 1: load PC from AR (jump).
- `o_addr`, output, 16: address bus; PC when `pc_out`=1, else AR.
- `o_pc`, output, 16: current PC.
- `o_busy`, output, 1: page-crossing fix-up cycle in progress.
- `o_page_cross`, output, 1: one-cycle pulse; the last index add carried out of the low byte.

## Operation

Reset values (asynchronous, `i_rst_n`=0):
- PC = `RESET_PC`; AR = 16'h0000; state = IDLE.
- `o_busy`=0, `o_page_cross`=0, `o_addr`=AR=16'h0000 unless `pc_out` is asserted.

`o_addr` is combinational: `pc_out ? PC : AR`. It is the only combinational path from inputs.

PC update, priority order:
- `i_pc_ld` → PC <= AR. AR is sampled before any same-edge AR update.
- else `pc_inc` → PC <= PC+1, modulo 2^16 (16'hFFFF → 16'h0000).
- else hold.
- PC updates are honoured in both states.

AR update in IDLE, priority order:
- `ldlo`=1, `ldhi`=0 → AR <= {8'h00, i_data}. Clears the high byte so zero-page fetches need one byte.
- `ldhi`=1, `ldlo`=0 → AR[15:8] <= i_data; low byte held.
- both set → AR <= {i_data, i_data}. Illegal upstream but deterministic.
- else `i_idx_add` → sum = AR[7:0] + i_idx_val (9-bit):
  - `i_idx_zp`=1: AR[7:0] <= sum[7:0]; AR[15:8] held (00 for zero page); no carry action.
  - `i_idx_zp`=0, sum[8]=0: AR[7:0] <= sum[7:0].
  - `i_idx_zp`=0, sum[8]=1: AR[7:0] <= sum[7:0]; `o_page_cross` <= 1; state <= FIX.

State machine:
- IDLE → FIX on non-zero-page carry (above).
- FIX: AR[15:8] <= AR[15:8]+1, modulo 256 (16'hFFxx wraps to 16'h00xx); `o_busy`=1; returns to IDLE next edge.
- In FIX, `ldlo`/`ldhi`/`i_idx_add` are ignored. PC controls still act.
- `o_page_cross` is registered: high exactly in the FIX cycle, low otherwise.

## Timing

- All register effects are visible the cycle after the control is sampled high.
- Non-carrying index add: corrected AR on `o_addr` 1 cycle after `i_idx_add`.
- Carrying absolute index add: 2 cycles after `i_idx_add`. During the intermediate cycle AR holds the wrong high byte (the dummy-read address), and `o_busy`=`o_page_cross`=1.
- Upstream must hold off new AR-affecting controls while `o_busy`=1. If it does not, they are dropped, not queued.
- Reset asserted mid-FIX: immediate return to IDLE with reset values. No pending increment survives.
- `i_pc_ld` in the same cycle as the `ldhi` that completes AR: PC gets the old AR.

## Test plan

1. **Reset, increment and wrap.**
   - Stimulus: reset; release with `pc_out`=1, `pc_inc`=1 for 4 cycles.
   - Response: `o_addr` = FFFC, FFFD, FFFE, FFFF, then 0000; `o_busy`=0 throughout.
2. **Absolute fetch and jump.**
   - Stimulus: `ldlo` with data 34 (ctrl 4'b1110), then `ldhi` with data 12 (4'b1101), then `i_pc_ld`.
   - Response: AR=1234; PC advances by 2 during the fetch; after `i_pc_ld`, `o_pc`=1234; with `pc_out`=0, `o_addr`=1234.
3. **Zero-page wrap.**
   - Stimulus: `ldlo` data F0, then `i_idx_add` with `i_idx_val`=20 and `i_idx_zp`=1.
   - Response: AR=0010; `o_page_cross` stays 0.
4. **Page crossing.**
   - Stimulus: AR=12F0, then `i_idx_add` with `i_idx_val`=20 and `i_idx_zp`=0.
   - Response: next cycle AR=1210 with `o_busy`=`o_page_cross`=1; following cycle AR=1310 with both flags 0.
   - Repeat with AR=FFF0: final AR=0010.
5. **Ignored and illegal controls.**
   - Stimulus: assert `ldlo` (data AA) during FIX.
   - Response: AR is unaffected by the `ldlo`; the high-byte increment still occurs.
   - Stimulus: assert `ldlo`+`ldhi` together with data 5A.
   - Response: AR=5A5A.
6. **Reset mid-FIX.**
   - Stimulus: pulse `i_rst_n` low asynchronously, between clock edges, during FIX.
   - Response: immediately AR=0000, PC=FFFC, `o_busy`=0; no increment on the following edge.
